// File: rtl/colour_bbox_pkg.sv
// Shared types and register map for the colour bounding-box tracker.
package colour_bbox_pkg;

   localparam int REG_CTRL      = 0;
   localparam int REG_STATUS    = 1;
   localparam int REG_FRAME_CNT = 2;
   localparam int REG_CH_BASE   = 8;

   localparam int CH_LO  = 0;
   localparam int CH_HI  = 1;
   localparam int CH_X   = 2;
   localparam int CH_Y   = 3;
   localparam int CH_CNT = 4;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      logic [15:0] xmin;
      logic [15:0] xmax;
      logic [15:0] ymin;
      logic [15:0] ymax;
      logic [30:0] count;
      logic        valid;
   } box_t;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_VIDEO, ST_CTRL_PKT} pkt_state_e;

   // Bits needed to hold coordinates 0..n-1.
   function automatic int coord_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/colour_bbox_channel.sv
// One colour channel: threshold-window compare, per-frame box accumulation, result latch
// and perimeter test of the latched box for the overlay.
module colour_bbox_channel
   import colour_bbox_pkg::*;
#(
   parameter int MIN_COUNT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] lo_i,
   input  logic [23:0] hi_i,
   input  logic        start_i,
   input  logic        pix_i,
   input  rgb_t        rgb_i,
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic        end_i,
   output box_t        res_o,
   output logic        border_o
);

   localparam box_t ACC_INIT = '{xmin: 16'hFFFF, xmax: 16'h0, ymin: 16'hFFFF, ymax: 16'h0,
                                 count: 31'd0, valid: 1'b0};

   rgb_t lo_q, hi_q;
   box_t acc_q, acc_d, res_q;
   logic hit;

   assign hit = pix_i &&
                (rgb_i.r >= lo_q.r) && (rgb_i.r <= hi_q.r) &&
                (rgb_i.g >= lo_q.g) && (rgb_i.g <= hi_q.g) &&
                (rgb_i.b >= lo_q.b) && (rgb_i.b <= hi_q.b);

   // acc_d already includes the current pixel so the eop pixel lands in the latched result.
   always_comb begin
      acc_d = acc_q;
      if (start_i) begin
         acc_d = ACC_INIT;
      end else if (hit) begin
         if (x_i < acc_q.xmin) acc_d.xmin = x_i;
         if (x_i > acc_q.xmax) acc_d.xmax = x_i;
         if (y_i < acc_q.ymin) acc_d.ymin = y_i;
         if (y_i > acc_q.ymax) acc_d.ymax = y_i;
         if (acc_q.count != '1) acc_d.count = acc_q.count + 31'd1;
      end
      acc_d.valid = (acc_d.count >= 31'(MIN_COUNT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo_q  <= '1;
         hi_q  <= '0;
         acc_q <= ACC_INIT;
         res_q <= '0;
      end else begin
         acc_q <= acc_d;
         if (start_i) begin
            lo_q <= rgb_t'(lo_i);
            hi_q <= rgb_t'(hi_i);
         end
         if (end_i) res_q <= acc_d;
      end
   end

   assign border_o = res_q.valid &&
      (((x_i == res_q.xmin || x_i == res_q.xmax) && y_i >= res_q.ymin && y_i <= res_q.ymax) ||
       ((y_i == res_q.ymin || y_i == res_q.ymax) && x_i >= res_q.xmin && x_i <= res_q.xmax));

   assign res_o = res_q;

endmodule

// File: rtl/colour_bbox_tracker.sv
// Multi-colour bounding-box tracker on an Avalon-ST RGB stream with an Avalon-MM
// register file, per-frame irq and optional overlay of the previous frame's boxes.
module colour_bbox_tracker
   import colour_bbox_pkg::*;
#(
   parameter int          IMG_W     = 640,
   parameter int          IMG_H     = 480,
   parameter int          N_COLOURS = 4,
   parameter int          MIN_COUNT = 64,
   parameter logic [23:0] BOX_RGB   = 24'hFFFFFF,
   localparam int         ADDR_W    = $clog2(8 + 8*N_COLOURS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] s_address,
   input  logic              s_read,
   input  logic              s_write,
   input  logic [31:0]       s_writedata,
   output logic [31:0]       s_readdata,
   output logic              irq,
   input  logic [23:0]       snk_data,
   input  logic              snk_valid,
   input  logic              snk_sop,
   input  logic              snk_eop,
   output logic              snk_ready,
   output logic [23:0]       src_data,
   output logic              src_valid,
   output logic              src_sop,
   output logic              src_eop,
   input  logic              src_ready
);

   localparam int          XW        = coord_w(IMG_W);
   localparam logic [31:0] FRAME_PIX = 32'(IMG_W * IMG_H);

   pkt_state_e state_q, state_d;
   logic rdy_q, beat, in_vid, hdr_vid, pix, restart, frame_end, size_bad, ovl, wr_status;
   logic [XW-1:0] x_q, x_d;
   logic [15:0]   y_q, y_d;
   logic [31:0]   pix_q, pix_d;

   logic [23:0] src_data_q;
   logic        src_valid_q, src_sop_q, src_eop_q;
   logic [1:0]  ctrl_q;
   logic        done_q, done_d, err_q, err_d, irq_q;
   logic [31:0] frame_cnt_q, rd_d, rd_q;
   logic [N_COLOURS-1:0][23:0] lo_sh_q, hi_sh_q;
   logic [N_COLOURS-1:0] ch_sel, border;
   logic [ADDR_W-1:0] ch_off;
   box_t res [N_COLOURS];
   logic unused;

   assign unused = ^s_writedata[31:24];

   // rdy_q keeps snk_ready low through reset and the edge that releases it.
   assign snk_ready = rdy_q & (~src_valid_q | src_ready);
   assign beat      = snk_valid & snk_ready;
   assign in_vid    = (state_q == ST_HDR) || (state_q == ST_VIDEO);
   assign hdr_vid   = beat & snk_sop & (snk_data[3:0] == 4'h0);
   assign pix       = beat & ~snk_sop & in_vid;
   assign restart   = beat & snk_sop & in_vid;
   assign frame_end = beat & snk_eop & (snk_sop ? (snk_data[3:0] == 4'h0) : in_vid);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      pix_d   = pix_q;
      if (beat) begin
         if (snk_sop)     state_d = (snk_data[3:0] == 4'h0) ? ST_HDR : ST_CTRL_PKT;
         else if (in_vid) state_d = ST_VIDEO;
         if (snk_eop)     state_d = ST_IDLE;
      end
      if (hdr_vid) begin
         x_d   = '0;
         y_d   = '0;
         pix_d = '0;
      end else if (pix) begin
         pix_d = pix_q + 32'd1;
         if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = y_q + 16'd1;
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   assign size_bad = (pix_d != FRAME_PIX);

   // Frame completion beats a same-cycle write-1-to-clear.
   always_comb begin
      wr_status = s_write && (s_address == ADDR_W'(REG_STATUS));
      done_d    = done_q & ~(wr_status & s_writedata[0]);
      err_d     = err_q  & ~(wr_status & s_writedata[1]);
      if (frame_end) begin
         done_d = 1'b1;
         if (size_bad) err_d = 1'b1;
      end
      if (restart) err_d = 1'b1;
   end

   assign ch_off = s_address - ADDR_W'(REG_CH_BASE);

   always_comb begin
      ch_sel = '0;
      for (int k = 0; k < N_COLOURS; k++)
         ch_sel[k] = (s_address >= ADDR_W'(REG_CH_BASE)) &&
                     (ch_off[ADDR_W-1:3] == (ADDR_W-3)'(k));
   end

   always_comb begin
      rd_d = '0;
      case (s_address)
         ADDR_W'(REG_CTRL):      rd_d = {30'd0, ctrl_q};
         ADDR_W'(REG_STATUS):    rd_d = {30'd0, err_q, done_q};
         ADDR_W'(REG_FRAME_CNT): rd_d = frame_cnt_q;
         default: ;
      endcase
      for (int k = 0; k < N_COLOURS; k++) begin
         if (ch_sel[k]) begin
            case (ch_off[2:0])
               3'(CH_LO):  rd_d = {8'd0, lo_sh_q[k]};
               3'(CH_HI):  rd_d = {8'd0, hi_sh_q[k]};
               3'(CH_X):   rd_d = {res[k].xmax, res[k].xmin};
               3'(CH_Y):   rd_d = {res[k].ymax, res[k].ymin};
               3'(CH_CNT): rd_d = {res[k].valid, res[k].count};
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < N_COLOURS; g++) begin : g_ch
      colour_bbox_channel #(.MIN_COUNT(MIN_COUNT)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .lo_i     (lo_sh_q[g]),
         .hi_i     (hi_sh_q[g]),
         .start_i  (hdr_vid),
         .pix_i    (pix),
         .rgb_i    (rgb_t'(snk_data)),
         .x_i      (16'(x_q)),
         .y_i      (y_q),
         .end_i    (frame_end),
         .res_o    (res[g]),
         .border_o (border[g])
      );
   end

   assign ovl = ctrl_q[0] & pix & (|border);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rdy_q       <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         pix_q       <= '0;
         src_data_q  <= '0;
         src_valid_q <= 1'b0;
         src_sop_q   <= 1'b0;
         src_eop_q   <= 1'b0;
         ctrl_q      <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         irq_q       <= 1'b0;
         frame_cnt_q <= '0;
         rd_q        <= '0;
         lo_sh_q     <= '1;
         hi_sh_q     <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
         x_q     <= x_d;
         y_q     <= y_d;
         pix_q   <= pix_d;
         done_q  <= done_d;
         err_q   <= err_d;
         irq_q   <= done_q & ctrl_q[1];
         if (frame_end) frame_cnt_q <= frame_cnt_q + 32'd1;
         if (s_read)    rd_q <= rd_d;
         if (s_write && s_address == ADDR_W'(REG_CTRL)) ctrl_q <= s_writedata[1:0];
         for (int k = 0; k < N_COLOURS; k++) begin
            if (s_write && ch_sel[k] && ch_off[2:0] == 3'(CH_LO)) lo_sh_q[k] <= s_writedata[23:0];
            if (s_write && ch_sel[k] && ch_off[2:0] == 3'(CH_HI)) hi_sh_q[k] <= s_writedata[23:0];
         end
         if (beat) begin
            src_valid_q <= 1'b1;
            src_data_q  <= ovl ? BOX_RGB : snk_data;
            src_sop_q   <= snk_sop;
            src_eop_q   <= snk_eop;
         end else if (src_ready) begin
            src_valid_q <= 1'b0;
         end
      end
   end

   assign src_data   = src_data_q;
   assign src_valid  = src_valid_q;
   assign src_sop    = src_sop_q;
   assign src_eop    = src_eop_q;
   assign s_readdata = rd_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_colour_bbox_tracker.sv
// Randomised scoreboard bench for colour_bbox_tracker on a small 16x8 image, two channels.
module tb_colour_bbox_tracker;

   localparam int          W    = 16;
   localparam int          H    = 8;
   localparam int          NC   = 2;
   localparam int          MINC = 4;
   localparam int          AW   = $clog2(8 + 8*NC);
   localparam logic [23:0] BOX  = 24'hFFFFFF;
   localparam logic [23:0] RED_LO = 24'hC80000, RED_HI = 24'hFF3232;
   localparam logic [23:0] BLU_LO = 24'h0000C8, BLU_HI = 24'h3232FF;

   logic          clk = 1'b0, reset = 1'b1;
   logic [AW-1:0] s_address = '0;
   logic          s_read = 1'b0, s_write = 1'b0;
   logic [31:0]   s_writedata = '0, s_readdata;
   logic          irq;
   logic [23:0]   snk_data = '0, src_data;
   logic          snk_valid = 1'b0, snk_sop = 1'b0, snk_eop = 1'b0, snk_ready;
   logic          src_valid, src_sop, src_eop, src_ready = 1'b1;

   always #5 clk = ~clk;

   colour_bbox_tracker #(.IMG_W(W), .IMG_H(H), .N_COLOURS(NC), .MIN_COUNT(MINC), .BOX_RGB(BOX)) dut (
      .clk(clk), .reset(reset), .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop),
      .snk_ready(snk_ready), .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
      .src_eop(src_eop), .src_ready(src_ready));

   int checks = 0, errors = 0;
   logic [25:0] exp_q[$];
   bit gaps = 0, rnd_ready = 0;
   int mid_at = -1;
   logic [23:0] mid_lo, mid_hi;

   // reference model state
   logic [23:0] sh_lo[NC], sh_hi[NC], ac_lo[NC], ac_hi[NC];
   int  bx0[NC], bx1[NC], by0[NC], by1[NC], bcnt[NC];
   bit  bval[NC];
   bit  m_ovl = 0, m_irqen = 0, m_done = 0, m_err = 0, in_frame = 0;
   int  m_fc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      src_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: scoreboard pop on every output handshake, plus hold and latency checks.
   bit held = 0, acc_prev = 0;
   logic [23:0] held_d;
   always @(negedge clk) begin
      if (!reset) begin
         if (held)     chk("hold", {7'd0, src_valid, src_data}, {7'd0, 1'b1, held_d});
         if (acc_prev) chk("latency", 32'(src_valid), 32'd1);
         held     = src_valid && !src_ready;
         held_d   = src_data;
         acc_prev = snk_valid && snk_ready;
         if (src_valid && src_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", {6'd0, src_data, src_sop, src_eop}, 32'hFFFFFFFF);
            else chk("stream", {6'd0, src_data, src_sop, src_eop}, {6'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic send(input logic [23:0] d, input logic sop, input logic eop);
      int n = 0;
      if (gaps) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      snk_valid = 1'b1; snk_data = d; snk_sop = sop; snk_eop = eop;
      forever begin
         @(negedge clk);
         if (snk_ready) break;
         if (++n > 1000) begin chk("snk_ready_timeout", 32'(snk_ready), 32'd1); break; end
      end
      @(posedge clk); #1;
      snk_valid = 1'b0;
   endtask

   task automatic push_send(input logic [23:0] d, input logic sop, input logic eop, input logic [23:0] e);
      exp_q.push_back({e, sop, eop});
      send(d, sop, eop);
   endtask

   task automatic mm_write(input int a, input logic [31:0] d);
      s_write = 1'b1; s_address = AW'(a); s_writedata = d;
      @(posedge clk); #1;
      s_write = 1'b0;
      if (a == 0) begin m_ovl = d[0]; m_irqen = d[1]; end
      if (a == 1) begin m_done &= ~d[0]; m_err &= ~d[1]; end
   endtask

   task automatic mm_read(input int a, output logic [31:0] d);
      s_read = 1'b1; s_address = AW'(a);
      @(posedge clk); #1;
      s_read = 1'b0;
      d = s_readdata;
   endtask

   task automatic set_thr(input int c, input logic [23:0] lo, input logic [23:0] hi);
      mm_write(8 + 8*c, {8'd0, lo});
      mm_write(9 + 8*c, {8'd0, hi});
      sh_lo[c] = lo; sh_hi[c] = hi;
   endtask

   function automatic bit in_win(input int c, input logic [23:0] p);
      int v, lo, hi;
      for (int s = 0; s < 3; s++) begin
         v  = int'(p >> (8*s)) & 255;
         lo = int'(ac_lo[c] >> (8*s)) & 255;
         hi = int'(ac_hi[c] >> (8*s)) & 255;
         if (v < lo || v > hi) return 0;
      end
      return 1;
   endfunction

   function automatic bit on_box(input int x, input int y);
      for (int c = 0; c < NC; c++)
         if (bval[c] && (((x == bx0[c] || x == bx1[c]) && y >= by0[c] && y <= by1[c]) ||
                         ((y == by0[c] || y == by1[c]) && x >= bx0[c] && x <= bx1[c])))
            return 1;
      return 0;
   endfunction

   task automatic send_video(input int npix, input bit with_eop);
      logic [23:0] img[$];
      logic [23:0] p;
      int x, y;
      for (int c = 0; c < NC; c++) begin ac_lo[c] = sh_lo[c]; ac_hi[c] = sh_hi[c]; end
      if (in_frame) m_err = 1;
      in_frame = 1;
      p = 24'($urandom);
      p[3:0] = 4'h0;
      push_send(p, 1'b1, with_eop && npix == 0, p);
      for (int i = 0; i < npix; i++) begin
         x = i % W; y = i / W;
         if (x >= 3 && x < 7 && y >= 2 && y < 5) p = 24'hF01010;
         else if (x >= 12 && x < 14 && y == 6)   p = 24'h0A14E6;
         else p = {8'($urandom_range(60, 180)), 8'($urandom_range(60, 180)), 8'($urandom_range(60, 180))};
         img.push_back(p);
         if (i == mid_at) set_thr(0, mid_lo, mid_hi);
         push_send(p, 1'b0, with_eop && i == npix - 1, (m_ovl && on_box(x, y)) ? BOX : p);
      end
      if (with_eop) begin
         for (int c = 0; c < NC; c++) begin
            bcnt[c] = 0; bx0[c] = 'hFFFF; bx1[c] = 0; by0[c] = 'hFFFF; by1[c] = 0;
            for (int i = 0; i < img.size(); i++) begin
               if (in_win(c, img[i])) begin
                  x = i % W; y = i / W;
                  bcnt[c]++;
                  if (x < bx0[c]) bx0[c] = x;
                  if (x > bx1[c]) bx1[c] = x;
                  if (y < by0[c]) by0[c] = y;
                  if (y > by1[c]) by1[c] = y;
               end
            end
            bval[c] = (bcnt[c] >= MINC);
         end
         m_done = 1; m_fc++;
         if (img.size() != W*H) m_err = 1;
         in_frame = 0;
      end
   endtask

   task automatic send_ctrl(input int n, input logic [23:0] last_d);
      logic [23:0] p;
      if (in_frame) m_err = 1;
      in_frame = 0;
      p = 24'($urandom);
      p[3:0] = 4'hF;
      push_send(p, 1'b1, 1'b0, p);
      for (int i = 0; i < n; i++) begin
         p = (i == n - 1) ? last_d : 24'($urandom);
         push_send(p, 1'b0, i == n - 1, p);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || src_valid) && n < 2000) begin @(posedge clk); #1; n++; end
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_valid", 32'(src_valid), 32'd0);
   endtask

   task automatic check_regs();
      logic [31:0] d;
      mm_read(1, d); chk("status", d, {30'd0, m_err, m_done});
      mm_read(2, d); chk("frame_cnt", d, 32'(m_fc));
      for (int c = 0; c < NC; c++) begin
         mm_read(10 + 8*c, d); chk($sformatf("ch%0d_x", c), d, {16'(bx1[c]), 16'(bx0[c])});
         mm_read(11 + 8*c, d); chk($sformatf("ch%0d_y", c), d, {16'(by1[c]), 16'(by0[c])});
         mm_read(12 + 8*c, d); chk($sformatf("ch%0d_cnt", c), d, {bval[c], 31'(bcnt[c])});
      end
      chk("irq", 32'(irq), 32'(m_done & m_irqen));
   endtask

   initial begin
      logic [31:0] d;
      for (int c = 0; c < NC; c++) begin
         sh_lo[c] = 24'hFFFFFF; sh_hi[c] = '0;
         bx0[c] = 0; bx1[c] = 0; by0[c] = 0; by1[c] = 0; bcnt[c] = 0; bval[c] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_snk_ready", 32'(snk_ready), 32'd0);
      chk("rst_src_valid", 32'(src_valid), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      mm_read(0, d); chk("rst_ctrl", d, 32'd0);
      mm_read(3, d); chk("unmapped", d, 32'd0);
      mm_read(13, d); chk("unmapped_ch", d, 32'd0);
      for (int c = 0; c < NC; c++) begin
         mm_read(8 + 8*c, d); chk("rst_lo", d, 32'h00FFFFFF);
         mm_read(9 + 8*c, d); chk("rst_hi", d, 32'd0);
      end
      check_regs();

      // thresholds still match nothing
      send_video(W*H, 1); drain(); check_regs();

      set_thr(0, RED_LO, RED_HI);
      set_thr(1, BLU_LO, BLU_HI);
      mm_read(8, d); chk("lo_rb", d, {8'd0, RED_LO});
      send_video(W*H, 1); drain(); check_regs();

      mm_write(1, 32'd3);
      mm_write(0, 32'd3);
      mm_read(1, d); chk("status_w1c", d, {30'd0, m_err, m_done});
      gaps = 1; rnd_ready = 1;
      send_video(W*H, 1); drain(); check_regs();

      // mid-frame threshold change takes effect only from the next frame
      mid_at = W*H/2; mid_lo = BLU_LO; mid_hi = BLU_HI;
      send_video(W*H, 1); drain(); check_regs();
      mid_at = -1;
      send_video(W*H, 1); drain(); check_regs();

      mm_write(1, 32'd3);
      send_ctrl(5, 24'h123450);
      send_video(20, 1); drain(); check_regs();

      // eop without a preceding video sop is ignored
      push_send(24'hABCDE0, 1'b0, 1'b0, 24'hABCDE0);
      push_send(24'h00FF00, 1'b0, 1'b1, 24'h00FF00);
      drain(); check_regs();

      // sop without eop restarts the frame and flags size_err
      mm_write(1, 32'd3);
      set_thr(0, RED_LO, RED_HI);
      send_video(10, 0);
      send_video(W*H, 1); drain(); check_regs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/colour_bbox_tracker.md
# colour_bbox_tracker

Parametrised multi-colour bounding-box tracker on the camera video path, between the camera frame source and the VIP frame buffer/ITC output. Compares every 24-bit RGB pixel of an Avalon-ST video stream against N_COLOURS programmable threshold windows. Accumulates per-colour bounding box and pixel count over each frame, and optionally overlays the previous frame's boxes on the passed-through video. Results and thresholds are exposed on an Avalon-MM slave for the Nios; an irq fires per completed frame.

## Interface
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- N_COLOURS, 4, colour channels (1..8)
- MIN_COUNT, 64, minimum matching pixels for a box to be reported valid
- BOX_RGB, 24'hFFFFFF, overlay colour
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- s_address  in  ADDR_W=$clog2(8+8*N_COLOURS)  word address
- s_read / s_write  in  1  MM strobes
- s_writedata  in  32  write data
- s_readdata  out  32  read data, read latency 1
- irq  out  1  level, high while STATUS.done set and CTRL.irq_en
- snk_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- snk_valid, snk_sop, snk_eop  in  1  sink handshake/framing
- snk_ready  out  1  sink backpressure
- src_data  out  24  output pixel
- src_valid, src_sop, src_eop  out  1  source framing
- src_ready  in  1  source backpressure

## Operation
- Register map, word offsets: 0 CTRL [0] overlay_en, [1] irq_en. 1 STATUS [0] done, [1] size_err, write-1-to-clear. 2 FRAME_CNT, 32-bit, wraps. Channel k at 8+8k: +0 LO {Rmin,Gmin,Bmin}, +1 HI {Rmax,Gmax,Bmax}, +2 {xmax[31:16],xmin[15:0]}, +3 {ymax,ymin}, +4 {valid[31],count[30:0]}. Results are read-only. Unmapped addresses read 0.
- Packet classification: first beat (sop) low nibble 0 = video packet, else control packet. Control packets pass unmodified and are not counted.
- Video packet: x counts 0..IMG_W-1 per accepted beat after the header. At IMG_W, x wraps to 0 and y increments.
- Match when Rmin≤R≤Rmax, Gmin≤G≤Gmax and Bmin≤B≤Bmax (unsigned). On match: count+1 (saturating), and xmin/xmax/ymin/ymax are updated by min/max.
- Per-frame accumulators initialise at video sop to xmin=ymin=all-ones, xmax=ymax=0, count=0.
- Frame end at video eop:
  - Results latch to the result registers. valid = count≥MIN_COUNT. Boxes with valid=0 still report raw extents.
  - FRAME_CNT+1. done set.
  - size_err set if the accepted pixel count ≠ IMG_W*IMG_H. Results still latch.
- Thresholds are shadowed. MM writes land in shadow and copy to active at the next video sop header beat, so a frame never mixes thresholds.
- Overlay, when overlay_en: a pixel whose (x,y) lies on the perimeter of any latched valid box is replaced by BOX_RGB. Perimeter means x∈{xmin,xmax} with ymin≤y≤ymax, or y∈{ymin,ymax} with xmin≤x≤xmax. Header beats are never altered.
- Reset: all outputs 0, snk_ready 0 until the first cycle after reset deasserts. CTRL=0, STATUS=0, FRAME_CNT=0, LO=24'hFFFFFF, HI=0 (match nothing), results 0.

## Timing
- One-stage registered pipeline. snk_ready = ~src_valid | src_ready. Data/sop/eop latency 1 cycle. No bubble under continuous valid/ready.
- src_valid holds, with src_data stable, while src_ready is low.
- Result registers and done update in the cycle after the eop beat is accepted. irq is asserted the following cycle.
- MM write to STATUS clearing done in the same cycle as an eop: set wins.
- Reset mid-frame discards the partial frame. The next sop restarts cleanly. An eop with no preceding video sop is ignored for statistics.
- sop without a preceding eop: restart the accumulators and flag size_err.

## Structure
- Package colour_bbox_pkg: register offset constants, rgb_t struct, box_t struct {xmin,xmax,ymin,ymax,count,valid}, and the coordinate width function.
- Sub-module colour_bbox_channel holds one channel's threshold compare, accumulators and result latch, and is instanced N_COLOURS times via generate. The top holds the counters, packet FSM (IDLE, HDR, VIDEO, CTRL_PKT), MM decode and overlay mux.

## Test plan
- Reset, then read all registers: LO=0x00FFFFFF, HI=0, STATUS=0, irq=0. First frame gives count=0, valid=0.
- 640×480 frame, ch0 window R≥200, G≤50, B≤50, with a 10×20 red rectangle at (100,50): xmin=100, xmax=109, ymin=50, ymax=69, count=200, valid=1, done=1.
- Same frame with overlay_en, run twice: second frame output pixels on the rectangle border equal 0xFFFFFF; all others are bit-identical to the input.
- Random src_ready (50% duty) plus random snk_valid gaps: output stream equals reference, no beat lost or duplicated, latency 1 when unstalled.
- Control packet (header 0xF) then a short 1000-pixel video frame: control beats pass unchanged, size_err=1, FRAME_CNT increments.
- Threshold write mid-frame: current frame results use old thresholds, next frame uses new ones.
